// File: rtl/wallace_inverse_divider.sv
// Radix-2 restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock.
// Flags divide-by-zero and quotient overflow up front; valid/ready handshake on both sides.
module wallace_inverse_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] in1,
    input  logic [WIDTH-1:0]   in2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quo,
    output logic [WIDTH-1:0]   rem,
    output logic               ovf,
    output logic               dz
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;

    // One restoring step. The partial remainder stays below d, so it fits in WIDTH bits;
    // the shifted value needs WIDTH+1 and bit WIDTH of the difference is the borrow.
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] q_nxt;

    assign r_sh      = {r, q[WIDTH-1]};
    assign diff      = r_sh - {1'b0, d};
    assign no_borrow = ~diff[WIDTH];
    assign r_nxt     = no_borrow ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
    assign q_nxt     = WIDTH'({q, no_borrow});

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quo       <= '0;
            rem       <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
            cnt       <= '0;
            r         <= '0;
            q         <= '0;
            d         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        d        <= in2;
                        in_ready <= 1'b0;
                        if (in2 == '0) begin
                            dz        <= 1'b1;
                            ovf       <= 1'b0;
                            quo       <= '1;
                            rem       <= in1[WIDTH-1:0];
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else if (in1[2*WIDTH-1:WIDTH] >= in2) begin
                            dz        <= 1'b0;
                            ovf       <= 1'b1;
                            quo       <= '1;
                            rem       <= in1[WIDTH-1:0];
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            r     <= in1[2*WIDTH-1:WIDTH];
                            q     <= in1[WIDTH-1:0];
                            cnt   <= CW'(WIDTH);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r   <= r_nxt;
                    q   <= q_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        quo       <= q_nxt;
                        rem       <= r_nxt;
                        ovf       <= 1'b0;
                        dz        <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wallace_inverse_divider.sv
// Directed bench for wallace_inverse_divider: latency, flags, backpressure, reset abort,
// round-trip of every 4x4 product and a batch of random operands against an arithmetic model.
module tb_wallace_inverse_divider;

    localparam int unsigned W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] in1;
    logic [W-1:0]   in2;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    logic           ovf;
    logic           dz;

    int passed = 0;
    int total  = 0;

    wallace_inverse_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quo       (quo),
        .rem       (rem),
        .ovf       (ovf),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Issue one op from a negedge in IDLE; latency counts edges from acceptance to the
    // edge that first samples out_valid high. elat < 0 skips the latency check.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er,
                          input logic eo, input logic ed,
                          input int elat, input logic release_out);
        int lat;
        chk($sformatf("in_ready_idle %0d/%0d", a, b), 32'(in_ready), 1);
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in1      = 8'($urandom);
        in2      = 4'($urandom);
        lat      = 1;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("out_valid %0d/%0d", a, b), 32'(out_valid), 1);
        if (elat >= 0) chk($sformatf("latency %0d/%0d", a, b), 32'(lat), 32'(elat));
        chk($sformatf("quo %0d/%0d", a, b), 32'(quo), 32'(eq));
        chk($sformatf("rem %0d/%0d", a, b), 32'(rem), 32'(er));
        chk($sformatf("ovf %0d/%0d", a, b), 32'(ovf), 32'(eo));
        chk($sformatf("dz %0d/%0d", a, b),  32'(dz),  32'(ed));
        if (release_out) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk($sformatf("in_ready_after %0d/%0d", a, b), 32'(in_ready), 1);
            chk($sformatf("out_valid_after %0d/%0d", a, b), 32'(out_valid), 0);
        end
    endtask

    initial begin
        logic [7:0] ra;
        logic [3:0] rb;
        logic [3:0] mq;
        logic [3:0] mr;
        logic       mo;
        logic       md;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in1       = '0;
        in2       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready",  32'(in_ready),  1);
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset quo",       32'(quo),       0);
        chk("reset rem",       32'(rem),       0);
        chk("reset ovf",       32'(ovf),       0);
        chk("reset dz",        32'(dz),        0);
        rst = 1'b0;

        // Normal divisions, including full-scale and zero dividend
        run_op(8'd100, 4'd7,  4'd14, 4'd2, 1'b0, 1'b0, 5, 1'b1);
        run_op(8'd225, 4'd15, 4'd15, 4'd0, 1'b0, 1'b0, 5, 1'b1);
        run_op(8'd0,   4'd5,  4'd0,  4'd0, 1'b0, 1'b0, 5, 1'b1);
        run_op(8'd127, 4'd8,  4'd15, 4'd7, 1'b0, 1'b0, 5, 1'b1);

        // Overflow and divide-by-zero short paths
        run_op(8'd120, 4'd3,  4'hF, 4'h8, 1'b1, 1'b0, 1, 1'b1);
        run_op(8'h37,  4'd0,  4'hF, 4'h7, 1'b0, 1'b1, 1, 1'b1);
        run_op(8'h80,  4'd8,  4'hF, 4'h0, 1'b1, 1'b0, 1, 1'b1);

        // Backpressure: result held, new requests ignored while DONE
        run_op(8'd100, 4'd7, 4'd14, 4'd2, 1'b0, 1'b0, 5, 1'b0);
        in_valid = 1'b1;
        in1      = 8'h37;
        in2      = 4'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp out_valid", 32'(out_valid), 1);
            chk("bp in_ready",  32'(in_ready),  0);
            chk("bp quo",       32'(quo),       14);
            chk("bp rem",       32'(rem),       2);
            chk("bp dz",        32'(dz),        0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp release in_ready",  32'(in_ready),  1);
        chk("bp release out_valid", 32'(out_valid), 0);

        // Reset during CALC aborts the op
        in1      = 8'd100;
        in2      = 4'd7;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort in_ready",  32'(in_ready),  1);
        chk("abort out_valid", 32'(out_valid), 0);
        chk("abort quo",       32'(quo),       0);
        chk("abort rem",       32'(rem),       0);
        chk("abort ovf",       32'(ovf),       0);
        chk("abort dz",        32'(dz),        0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort no result", 32'(out_valid), 0);
        end
        run_op(8'd77, 4'd9, 4'd8, 4'd5, 1'b0, 1'b0, 5, 1'b1);

        // Round-trip every 4x4 product through the divider
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0)
                    run_op(8'(a * b), 4'(b), 4'hF, 4'h0, 1'b0, 1'b1, 1, 1'b1);
                else
                    run_op(8'(a * b), 4'(b), 4'(a), 4'h0, 1'b0, 1'b0, 5, 1'b1);
            end
        end

        // Random operands against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 4'($urandom_range(0, 15));
            if (rb == 0) begin
                mq = 4'hF; mr = ra[3:0]; mo = 1'b0; md = 1'b1;
            end else if (ra[7:4] >= rb) begin
                mq = 4'hF; mr = ra[3:0]; mo = 1'b1; md = 1'b0;
            end else begin
                mq = 4'(int'(ra) / int'(rb));
                mr = 4'(int'(ra) % int'(rb));
                mo = 1'b0;
                md = 1'b0;
            end
            run_op(ra, rb, mq, mr, mo, md, (mo || md) ? 1 : 5, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
